// File: rtl/mesh_cfg_loader.sv
// Programming sequencer: streams per-session cfg words into the PE array, then raises mesh_run.
// Latency: accept at t -> pe_load/pe_instruction/pe_data/loaded_mask at t+1; mesh_run at t+2 after the last word.
// Backpressure: cfg_ready is high only in PROG with words remaining; it is never high in IDLE or RUN.
module mesh_cfg_loader #(
    parameter int NUM_PE = 16,
    parameter int ID_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_start,
    input  logic [CNT_W-1:0]  prog_count,
    input  logic              prog_abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_bcast,
    input  logic [ID_W-1:0]   cfg_pe_id,
    input  logic [3:0]        cfg_instr,
    input  logic [31:0]       cfg_data,
    output logic [NUM_PE-1:0] pe_load,
    output logic [3:0]        pe_instruction,
    output logic [31:0]       pe_data,
    output logic              mesh_run,
    output logic [NUM_PE-1:0] loaded_mask,
    output logic              busy,
    output logic              err_bad_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic            bcast;
        logic [ID_W-1:0] pe_id;
        logic [3:0]      instr;
        logic [31:0]     data;
    } cfg_word_t;

    localparam logic [ID_W:0] PE_LIMIT = (ID_W+1)'(NUM_PE);

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    cfg_word_t          cfg_word;
    logic               accept;
    logic               id_in_range;
    logic               bad_id;
    logic               go_idle;
    logic               new_session;
    logic [NUM_PE-1:0]  strobe;

    assign cfg_word    = '{bcast: cfg_bcast, pe_id: cfg_pe_id, instr: cfg_instr, data: cfg_data};
    assign accept      = cfg_valid & cfg_ready;
    assign id_in_range = {1'b0, cfg_word.pe_id} < PE_LIMIT;
    assign bad_id      = accept & ~cfg_word.bcast & ~id_in_range;
    // Abort beats start; start is only honoured outside PROG.
    assign go_idle     = prog_abort & (state != IDLE);
    assign new_session = prog_start & (state != PROG) & ~go_idle;

    always_comb begin
        strobe = '0;
        if (accept) begin
            if (cfg_word.bcast) begin
                strobe = '1;
            end else if (id_in_range) begin
                strobe = NUM_PE'(1) << cfg_word.pe_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            remaining      <= '0;
            cfg_ready      <= 1'b0;
            pe_load        <= '0;
            pe_instruction <= '0;
            pe_data        <= '0;
            mesh_run       <= 1'b0;
            loaded_mask    <= '0;
            busy           <= 1'b0;
            err_bad_id     <= 1'b0;
        end else begin
            pe_load <= strobe;
            if (accept) begin
                pe_instruction <= cfg_word.instr;
                pe_data        <= cfg_word.data;
            end
            loaded_mask <= loaded_mask | strobe;
            if (bad_id) begin
                err_bad_id <= 1'b1;
            end

            if (go_idle) begin
                state     <= IDLE;
                cfg_ready <= 1'b0;
                busy      <= 1'b0;
                mesh_run  <= 1'b0;
            end else if (new_session) begin
                remaining   <= prog_count;
                loaded_mask <= '0;
                err_bad_id  <= 1'b0;
                if (prog_count != '0) begin
                    state     <= PROG;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b1;
                    mesh_run  <= 1'b0;
                end else begin
                    state     <= RUN;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                    mesh_run  <= 1'b1;
                end
            end else if ((state == PROG) && accept) begin
                remaining <= remaining - CNT_W'(1);
                // Last word: mesh_run waits one RUN cycle so its strobe lands first.
                if (remaining == CNT_W'(1)) begin
                    state     <= RUN;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            end else if (state == RUN) begin
                mesh_run <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mesh_cfg_loader.sv
// Randomized scoreboard bench for mesh_cfg_loader with a 12-PE array so out-of-range ids are reachable.
// The driver pushes expected per-cycle outputs from a session-level model; a monitor pops and compares.
module tb_mesh_cfg_loader;

    localparam int NP    = 12;
    localparam int IDW   = 4;
    localparam int CNTW  = 16;

    localparam int M_IDLE = 0;
    localparam int M_PROG = 1;
    localparam int M_RUN  = 2;

    logic            clk;
    logic            reset;
    logic            prog_start;
    logic [CNTW-1:0] prog_count;
    logic            prog_abort;
    logic            cfg_valid;
    logic            cfg_ready;
    logic            cfg_bcast;
    logic [IDW-1:0]  cfg_pe_id;
    logic [3:0]      cfg_instr;
    logic [31:0]     cfg_data;
    logic [NP-1:0]   pe_load;
    logic [3:0]      pe_instruction;
    logic [31:0]     pe_data;
    logic            mesh_run;
    logic [NP-1:0]   loaded_mask;
    logic            busy;
    logic            err_bad_id;

    mesh_cfg_loader #(.NUM_PE(NP), .ID_W(IDW), .CNT_W(CNTW)) dut (
        .clk            (clk),
        .reset          (reset),
        .prog_start     (prog_start),
        .prog_count     (prog_count),
        .prog_abort     (prog_abort),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_bcast      (cfg_bcast),
        .cfg_pe_id      (cfg_pe_id),
        .cfg_instr      (cfg_instr),
        .cfg_data       (cfg_data),
        .pe_load        (pe_load),
        .pe_instruction (pe_instruction),
        .pe_data        (pe_data),
        .mesh_run       (mesh_run),
        .loaded_mask    (loaded_mask),
        .busy           (busy),
        .err_bad_id     (err_bad_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] load;
        logic [3:0]    instr;
        logic [31:0]   data;
        logic          run;
        logic [NP-1:0] mask;
        logic          busy;
        logic          err;
        logic          ready;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int mon_cyc  = 0;

    // Session-level reference state
    int            m_mode  = M_IDLE;
    int            m_left  = 0;
    bit            m_run   = 1'b0;
    logic [NP-1:0] m_mask  = '0;
    bit            m_err   = 1'b0;
    logic [3:0]    m_instr = '0;
    logic [31:0]   m_data  = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, mon_cyc, act, exp_v);
    endtask

    task automatic model_step(input bit r, input bit st, input int cnt, input bit ab,
                              input bit v, input bit bc, input int id,
                              input logic [3:0] ins, input logic [31:0] dat);
        exp_t          e;
        bit            acc;
        logic [NP-1:0] stb;
        stb = '0;
        acc = !r && v && (m_mode == M_PROG);
        if (r) begin
            m_mode = M_IDLE; m_left = 0; m_run = 0; m_mask = '0; m_err = 0;
            m_instr = '0; m_data = '0;
        end else begin
            if (acc) begin
                if (bc) stb = '1;
                else if (id < NP) stb[id] = 1'b1;
                else m_err = 1'b1;
                m_instr = ins;
                m_data  = dat;
                m_mask  = m_mask | stb;
            end
            if (ab && m_mode != M_IDLE) begin
                m_mode = M_IDLE;
                m_run  = 0;
            end else if (st && m_mode != M_PROG) begin
                m_mask = '0;
                m_err  = 0;
                if (cnt > 0) begin
                    m_mode = M_PROG; m_left = cnt; m_run = 0;
                end else begin
                    m_mode = M_RUN; m_run = 1;
                end
            end else if (m_mode == M_PROG && acc) begin
                m_left--;
                if (m_left == 0) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                m_run = 1;
            end
        end
        e.load  = stb;
        e.instr = m_instr;
        e.data  = m_data;
        e.run   = m_run;
        e.mask  = m_mask;
        e.busy  = (m_mode == M_PROG);
        e.err   = m_err;
        e.ready = (m_mode == M_PROG);
        q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit st, input int cnt, input bit ab,
                         input bit v, input bit bc, input int id,
                         input logic [3:0] ins, input logic [31:0] dat);
        @(negedge clk);
        reset      = r;
        prog_start = st;
        prog_count = CNTW'(cnt);
        prog_abort = ab;
        cfg_valid  = v;
        cfg_bcast  = bc;
        cfg_pe_id  = IDW'(id);
        cfg_instr  = ins;
        cfg_data   = dat;
        model_step(r, st, cnt, ab, v, bc, id, ins, dat);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic word(input bit bc, input int id, input logic [3:0] ins, input logic [31:0] dat);
        drive(0, 0, 0, 0, 1, bc, id, ins, dat);
    endtask

    task automatic start(input int cnt);
        drive(0, 1, cnt, 0, 0, 0, 0, 4'h0, 32'h0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                mon_cyc++;
                check("pe_load",        32'(pe_load),        32'(e.load));
                check("pe_instruction", 32'(pe_instruction), 32'(e.instr));
                check("pe_data",        pe_data,             e.data);
                check("mesh_run",       32'(mesh_run),       32'(e.run));
                check("loaded_mask",    32'(loaded_mask),    32'(e.mask));
                check("busy",           32'(busy),           32'(e.busy));
                check("err_bad_id",     32'(err_bad_id),     32'(e.err));
                check("cfg_ready",      32'(cfg_ready),      32'(e.ready));
            end
        end
    end

    initial begin
        reset = 1'b1; prog_start = 1'b0; prog_count = '0; prog_abort = 1'b0;
        cfg_valid = 1'b0; cfg_bcast = 1'b0; cfg_pe_id = '0; cfg_instr = '0; cfg_data = '0;

        drive(1, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0);
        drive(1, 0, 0, 0, 1, 0, 0, 4'h0, 32'h0);
        idle(1);

        // Three unicast words, then let mesh_run come up
        start(3);
        word(0, 0, 4'h1, 32'h3F80_0000);
        word(0, 5, 4'h1, 32'h3F80_0000);
        word(0, 11, 4'h1, 32'h3F80_0000);
        idle(3);

        // Valid held high across the start: bcast then three unicast words
        drive(0, 1, 4, 0, 1, 0, 1, 4'h7, 32'h1111_0000);
        word(1, 0, 4'h3, 32'hAAAA_0001);
        word(0, 1, 4'h4, 32'hAAAA_0002);
        word(0, 2, 4'h2, 32'hAAAA_0003);
        word(0, 3, 4'h5, 32'hAAAA_0004);
        word(0, 4, 4'h6, 32'hAAAA_0005);
        idle(1);

        // Out-of-range id, then the next start clears the error
        start(2);
        word(0, 13, 4'h1, 32'hDEAD_BEEF);
        word(0, 4, 4'h1, 32'h0000_0044);
        idle(2);
        start(1);
        word(0, 2, 4'h9, 32'h0000_0022);
        idle(2);

        // Zero-count start, then restart from RUN
        start(0);
        idle(2);
        start(2);
        word(0, 6, 4'h1, 32'h6);
        word(0, 7, 4'h1, 32'h7);
        idle(2);

        // Abort after one of five words
        start(5);
        word(0, 3, 4'h8, 32'h3333);
        drive(0, 1, 2, 1, 0, 0, 0, 4'h0, 32'h0);
        idle(2);

        // Stall mid-session, then reset mid-PROG
        start(3);
        word(0, 1, 4'h1, 32'h1);
        idle(10);
        word(0, 2, 4'h1, 32'h2);
        drive(1, 0, 0, 0, 1, 0, 3, 4'h1, 32'h3);
        idle(2);

        for (int k = 0; k < 2500; k++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 11) == 0,
                  int'($urandom_range(0, 6)),
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)),
                  4'($urandom),
                  $urandom);
        end

        for (int k = 0; k < 4 && q.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
